// File: rtl/block_scanout.sv
// Raster scan-out of a 4x4-pixel block store into an 8-bit valid/ready pixel stream.
// Define SCANOUT_DOUBLE_EN to emit every pixel and every line twice (2x upscale).
module block_scanout #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int AW   = 13
) (
    input  logic          GCLK,
    input  logic          RSTN,
    input  logic          en,
    output logic [AW-1:0] mem_addr,
    input  logic [127:0]  mem_rd_data,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_sol,
    output logic          pix_sof,
    output logic          frame_done,
    output logic          busy
);

`ifdef SCANOUT_DOUBLE_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int COLS  = FB_W / 4;
    localparam int OUT_W = FB_W * SCALE;
    localparam int OUT_H = FB_H * SCALE;
    localparam int CW    = $clog2(COLS + 1);
    localparam int YW    = $clog2(FB_H + 1);
    localparam int XW    = $clog2(OUT_W + 1);
    localparam int EW    = $clog2(OUT_H + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [YW-1:0] FY_LAST  = YW'(FB_H - 1);
    localparam logic [XW-1:0] EX_LAST  = XW'(OUT_W - 1);
    localparam logic [EW-1:0] EY_LAST  = EW'(OUT_H - 1);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state;
    logic [CW-1:0] f_col;
    logic [YW-1:0] f_y;
    logic [AW-1:0] f_base;
    logic          f_done;
    logic          req_q, ret_q;
    logic [1:0]    req_row, ret_row;
    logic [31:0]   nxt, cur;
    logic          nxt_full;
    logic [1:0]    cnt;
    logic [XW-1:0] e_x;
    logic [EW-1:0] e_y;
`ifdef SCANOUT_DOUBLE_EN
    logic          rep;
    logic          f_lrep;
`endif

    logic          accept, cur_last, pix_step, line_step;
    logic          load_bus, load_nxt, cur_drain, last_pix, fetch_go, valid_next;
    logic [31:0]   row_data;
    logic [XW-1:0] ex_nxt, pos_x;
    logic [EW-1:0] ey_nxt, pos_y;

    assign pix_data = cur[31:24];

    // A returned row bypasses NXT straight into CUR whenever CUR would otherwise be empty.
    always_comb begin
        accept = pix_valid && pix_ready;
`ifdef SCANOUT_DOUBLE_EN
        pix_step  = rep;
        line_step = f_lrep;
`else
        pix_step  = 1'b1;
        line_step = 1'b1;
`endif
        cur_last   = (cnt == 2'd3) && pix_step;
        load_bus   = ret_q && (!pix_valid || (accept && cur_last && !nxt_full));
        load_nxt   = accept && cur_last && nxt_full;
        cur_drain  = accept && cur_last && !nxt_full && !load_bus;
        last_pix   = accept && (e_x == EX_LAST) && (e_y == EY_LAST);
        fetch_go   = (state != IDLE) && !f_done && !nxt_full && !req_q && !ret_q;
        valid_next = (pix_valid && !cur_drain) || load_bus;
        case (ret_row)
            2'd0:    row_data = mem_rd_data[127:96];
            2'd1:    row_data = mem_rd_data[95:64];
            2'd2:    row_data = mem_rd_data[63:32];
            default: row_data = mem_rd_data[31:0];
        endcase
        if (e_x == EX_LAST) begin
            ex_nxt = '0;
            ey_nxt = (e_y == EY_LAST) ? '0 : e_y + EW'(1);
        end else begin
            ex_nxt = e_x + XW'(1);
            ey_nxt = e_y;
        end
        pos_x = accept ? ex_nxt : e_x;
        pos_y = accept ? ey_nxt : e_y;
    end

    always_ff @(posedge GCLK) begin
        if (!RSTN) begin
            state      <= IDLE;
            f_col      <= '0;
            f_y        <= '0;
            f_base     <= '0;
            f_done     <= 1'b0;
            req_q      <= 1'b0;
            ret_q      <= 1'b0;
            req_row    <= '0;
            ret_row    <= '0;
            nxt        <= '0;
            nxt_full   <= 1'b0;
            cur        <= '0;
            cnt        <= '0;
            e_x        <= '0;
            e_y        <= '0;
            mem_addr   <= '0;
            pix_valid  <= 1'b0;
            pix_sol    <= 1'b0;
            pix_sof    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
`ifdef SCANOUT_DOUBLE_EN
            rep        <= 1'b0;
            f_lrep     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            req_q      <= fetch_go;
            ret_q      <= req_q;
            ret_row    <= req_row;

            // Fetch pointer walks blocks in raster order, one read at a time.
            if (fetch_go) begin
                mem_addr <= f_base + AW'(f_col);
                req_row  <= f_y[1:0];
                if (f_col == COL_LAST) begin
                    f_col <= '0;
`ifdef SCANOUT_DOUBLE_EN
                    f_lrep <= ~f_lrep;
`endif
                    if (line_step) begin
                        if (f_y == FY_LAST) begin
                            f_y    <= '0;
                            f_base <= '0;
                            f_done <= 1'b1;
                        end else begin
                            f_y <= f_y + YW'(1);
                            if (f_y[1:0] == 2'd3)
                                f_base <= f_base + COLS_A;
                        end
                    end
                end else begin
                    f_col <= f_col + CW'(1);
                end
            end

            if (ret_q && !load_bus) begin
                nxt      <= row_data;
                nxt_full <= 1'b1;
            end else if (load_nxt) begin
                nxt_full <= 1'b0;
            end

            if (load_bus) begin
                cur <= row_data;
                cnt <= '0;
`ifdef SCANOUT_DOUBLE_EN
                rep <= 1'b0;
`endif
            end else if (load_nxt) begin
                cur <= nxt;
                cnt <= '0;
`ifdef SCANOUT_DOUBLE_EN
                rep <= 1'b0;
`endif
            end else if (accept) begin
`ifdef SCANOUT_DOUBLE_EN
                rep <= ~rep;
`endif
                if (pix_step) begin
                    cur <= {cur[23:0], 8'h00};
                    cnt <= cnt + 2'd1;
                end
            end

            if (accept) begin
                e_x <= ex_nxt;
                e_y <= ey_nxt;
            end
            pix_valid <= valid_next;
            pix_sol   <= valid_next && (pos_x == '0);
            pix_sof   <= valid_next && (pos_x == '0) && (pos_y == '0);

            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= FILL;
                        busy   <= 1'b1;
                        f_col  <= '0;
                        f_y    <= '0;
                        f_base <= '0;
                        f_done <= 1'b0;
`ifdef SCANOUT_DOUBLE_EN
                        f_lrep <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (load_bus)
                        state <= RUN;
                end
                RUN: begin
                    if (last_pix) begin
                        frame_done <= 1'b1;
                        f_col      <= '0;
                        f_y        <= '0;
                        f_base     <= '0;
                        f_done     <= 1'b0;
`ifdef SCANOUT_DOUBLE_EN
                        f_lrep     <= 1'b0;
`endif
                        if (en) begin
                            state <= FILL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
